// File: rtl/reg_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : reg_bus_arbiter
// Description : Round-robin sharing of one register-file bus between two
//               requesters, each with a 1-deep pending slot and read return.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_bus_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 16,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk_i,
    input  logic              rst_n_i,

    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_wdata_i,
    input  logic              m0_wr_en_i,
    input  logic              m0_rd_en_i,
    output logic [DATA_W-1:0] m0_rdata_o,
    output logic              m0_rd_valid_o,
    output logic              m0_busy_o,

    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_wdata_i,
    input  logic              m1_wr_en_i,
    input  logic              m1_rd_en_i,
    output logic [DATA_W-1:0] m1_rdata_o,
    output logic              m1_rd_valid_o,
    output logic              m1_busy_o,

    output logic [ADDR_W-1:0] reg_addr_o,
    output logic [DATA_W-1:0] reg_wdata_o,
    output logic              reg_wr_en_o,
    output logic              reg_rd_en_o,
    input  logic [DATA_W-1:0] reg_rdata_i,

    output logic [1:0]        err_overrun_o,
    input  logic              clr_err_i
);

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_issue   = 2'd1;
    localparam logic [1:0] c_st_wait_rd = 2'd2;

    localparam logic [1:0] c_cnt_load = (RD_LATENCY > 0) ? 2'(RD_LATENCY - 1) : 2'd0;

    logic [ADDR_W-1:0] w_in_addr  [2];
    logic [DATA_W-1:0] w_in_wdata [2];
    logic [1:0]        w_in_wr;
    logic [1:0]        w_in_rd;

    logic [1:0]        w_vld;
    logic [1:0]        w_wr;
    logic [ADDR_W-1:0] w_slot_addr  [2];
    logic [DATA_W-1:0] w_slot_wdata [2];
    logic [1:0]        w_err;
    logic [1:0]        w_slot_done;
    logic              w_done_any;
    logic              w_pick;

    logic [1:0]        r_state;
    logic              r_last;
    logic              r_gnt;
    logic [1:0]        r_cnt;
    logic [ADDR_W-1:0] r_reg_addr;
    logic [DATA_W-1:0] r_reg_wdata;
    logic              r_reg_wr;
    logic              r_reg_rd;
    logic [1:0]        r_rd_valid;
    logic [DATA_W-1:0] r_rdata [2];

    assign w_in_addr[0]  = m0_addr_i;
    assign w_in_addr[1]  = m1_addr_i;
    assign w_in_wdata[0] = m0_wdata_i;
    assign w_in_wdata[1] = m1_wdata_i;
    assign w_in_wr       = {m1_wr_en_i, m0_wr_en_i};
    assign w_in_rd       = {m1_rd_en_i, m0_rd_en_i};

    // A slot frees when its write issues, or when its read data is captured.
    assign w_done_any = ((r_state == c_st_issue) && (r_reg_wr || (RD_LATENCY == 0))) ||
                        ((r_state == c_st_wait_rd) && (r_cnt == 2'd0));
    assign w_slot_done = w_done_any ? (r_gnt ? 2'b10 : 2'b01) : 2'b00;

    assign w_pick = (w_vld == 2'b11) ? ~r_last : w_vld[1];

    generate
        for (genvar n = 0; n < 2; n++) begin : g_port
            logic              r_vld;
            logic              r_wr;
            logic              r_err_bit;
            logic [ADDR_W-1:0] r_addr;
            logic [DATA_W-1:0] r_wdata;
            logic              w_strobe;
            logic              w_set;

            assign w_strobe = w_in_wr[n] | w_in_rd[n];
            // Overrun: simultaneous wr+rd, or any strobe into an occupied slot.
            assign w_set    = (w_in_wr[n] & w_in_rd[n]) | (r_vld & w_strobe);

            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    r_vld     <= 1'b0;
                    r_wr      <= 1'b0;
                    r_addr    <= '0;
                    r_wdata   <= '0;
                    r_err_bit <= 1'b0;
                end else begin
                    if (w_slot_done[n]) begin
                        r_vld <= 1'b0;
                    end else if (!r_vld && w_strobe) begin
                        r_vld   <= 1'b1;
                        r_wr    <= w_in_wr[n];
                        r_addr  <= w_in_addr[n];
                        r_wdata <= w_in_wdata[n];
                    end
                    r_err_bit <= w_set | (r_err_bit & ~clr_err_i);
                end
            end

            assign w_vld[n]        = r_vld;
            assign w_wr[n]         = r_wr;
            assign w_slot_addr[n]  = r_addr;
            assign w_slot_wdata[n] = r_wdata;
            assign w_err[n]        = r_err_bit;
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= c_st_idle;
            r_last      <= 1'b1;
            r_gnt       <= 1'b0;
            r_cnt       <= 2'd0;
            r_reg_addr  <= '0;
            r_reg_wdata <= '0;
            r_reg_wr    <= 1'b0;
            r_reg_rd    <= 1'b0;
            r_rd_valid  <= 2'b00;
            r_rdata[0]  <= '0;
            r_rdata[1]  <= '0;
        end else begin
            r_reg_wr   <= 1'b0;
            r_reg_rd   <= 1'b0;
            r_rd_valid <= 2'b00;
            case (r_state)
                c_st_idle: begin
                    if (|w_vld) begin
                        r_gnt       <= w_pick;
                        r_reg_addr  <= w_slot_addr[w_pick];
                        r_reg_wdata <= w_slot_wdata[w_pick];
                        r_reg_wr    <= w_wr[w_pick];
                        r_reg_rd    <= ~w_wr[w_pick];
                        r_state     <= c_st_issue;
                    end
                end
                c_st_issue: begin
                    r_last <= r_gnt;
                    if (r_reg_wr) begin
                        r_state <= c_st_idle;
                    end else if (RD_LATENCY == 0) begin
                        r_rdata[r_gnt]    <= reg_rdata_i;
                        r_rd_valid[r_gnt] <= 1'b1;
                        r_state           <= c_st_idle;
                    end else begin
                        r_cnt   <= c_cnt_load;
                        r_state <= c_st_wait_rd;
                    end
                end
                c_st_wait_rd: begin
                    if (r_cnt == 2'd0) begin
                        r_rdata[r_gnt]    <= reg_rdata_i;
                        r_rd_valid[r_gnt] <= 1'b1;
                        r_state           <= c_st_idle;
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign reg_addr_o    = r_reg_addr;
    assign reg_wdata_o   = r_reg_wdata;
    assign reg_wr_en_o   = r_reg_wr;
    assign reg_rd_en_o   = r_reg_rd;
    assign m0_rdata_o    = r_rdata[0];
    assign m1_rdata_o    = r_rdata[1];
    assign m0_rd_valid_o = r_rd_valid[0];
    assign m1_rd_valid_o = r_rd_valid[1];
    assign m0_busy_o     = w_vld[0];
    assign m1_busy_o     = w_vld[1];
    assign err_overrun_o = w_err;

endmodule
`default_nettype wire

// File: tb/tb_reg_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_bus_arbiter
// Description : Scoreboard bench for reg_bus_arbiter with a transaction-level
//               model of slots, round-robin order and read return timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_bus_arbiter;

    localparam int c_lat = 2;
    localparam int c_inf = 32'h7fffffff;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  m_addr  [2];
    logic [15:0] m_wdata [2];
    logic [1:0]  m_wr = 2'b00;
    logic [1:0]  m_rd = 2'b00;
    logic [15:0] m_rdata [2];
    logic [1:0]  m_rdv;
    logic [1:0]  m_busy;
    logic [7:0]  reg_addr;
    logic [15:0] reg_wdata;
    logic        reg_wr;
    logic        reg_rd;
    logic [15:0] reg_rdata = 16'h0;
    logic [1:0]  err;
    logic        clr_err = 1'b0;

    reg_bus_arbiter #(.ADDR_W(8), .DATA_W(16), .RD_LATENCY(c_lat)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .m0_addr_i(m_addr[0]), .m0_wdata_i(m_wdata[0]), .m0_wr_en_i(m_wr[0]), .m0_rd_en_i(m_rd[0]),
        .m0_rdata_o(m_rdata[0]), .m0_rd_valid_o(m_rdv[0]), .m0_busy_o(m_busy[0]),
        .m1_addr_i(m_addr[1]), .m1_wdata_i(m_wdata[1]), .m1_wr_en_i(m_wr[1]), .m1_rd_en_i(m_rd[1]),
        .m1_rdata_o(m_rdata[1]), .m1_rd_valid_o(m_rdv[1]), .m1_busy_o(m_busy[1]),
        .reg_addr_o(reg_addr), .reg_wdata_o(reg_wdata), .reg_wr_en_o(reg_wr),
        .reg_rd_en_o(reg_rd), .reg_rdata_i(reg_rdata),
        .err_overrun_o(err), .clr_err_i(clr_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [7:0] addr; logic [15:0] wdata; logic wr; int push; } req_t;
    typedef struct { logic [15:0] data; int due; } rsp_t;

    req_t        bus_q [2][$];
    rsp_t        rd_q  [2][$];
    rsp_t        samp_q[$];
    bit          has_acc [2];
    int          acc_cyc [2];
    int          free_cyc[2];
    logic [15:0] mem [256];
    logic [15:0] exp_rdata[2];
    logic [1:0]  exp_err = 2'b00;
    logic [1:0]  exp_err_nxt = 2'b00;
    bit          last_g = 1'b1;
    int          bus_next = 0;
    logic [7:0]  last_addr = 8'h0;
    logic [15:0] last_wdata = 16'h0;
    int          n_tests = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit busy_m(int n, int k);
        return has_acc[n] && (acc_cyc[n] < k) && (k < free_cyc[n]);
    endfunction

    task automatic model_reset();
        for (int n = 0; n < 2; n++) begin
            bus_q[n].delete();
            rd_q[n].delete();
            has_acc[n]   = 1'b0;
            acc_cyc[n]   = 0;
            free_cyc[n]  = 0;
            exp_rdata[n] = 16'h0;
        end
        samp_q.delete();
        exp_err     = 2'b00;
        exp_err_nxt = 2'b00;
        last_g      = 1'b1;
        bus_next    = 0;
        last_addr   = 8'h0;
        last_wdata  = 16'h0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_strobes"}, 32'({reg_wr, reg_rd}), 0);
        check({tag, "_addr"}, 32'(reg_addr), 0);
        check({tag, "_wdata"}, 32'(reg_wdata), 0);
        check({tag, "_busy"}, 32'(m_busy), 0);
        check({tag, "_rdv"}, 32'(m_rdv), 0);
        check({tag, "_rdata0"}, 32'(m_rdata[0]), 0);
        check({tag, "_rdata1"}, 32'(m_rdata[1]), 0);
        check({tag, "_err"}, 32'(err), 0);
    endtask

    // One stimulus cycle; pushes accepted requests and the expected error state.
    task automatic step(input logic [1:0] wr, input logic [1:0] rd, input logic [7:0] a0,
                        input logic [7:0] a1, input logic [15:0] d0, input logic [15:0] d1,
                        input logic clr);
        logic [1:0] set;
        @(posedge clk); #1;
        exp_err    = exp_err_nxt;
        m_wr       = wr;
        m_rd       = rd;
        m_addr[0]  = a0;
        m_addr[1]  = a1;
        m_wdata[0] = d0;
        m_wdata[1] = d1;
        clr_err    = clr;
        set = 2'b00;
        for (int n = 0; n < 2; n++) begin
            if (wr[n] || rd[n]) begin
                if (wr[n] && rd[n]) set[n] = 1'b1;
                if (busy_m(n, cyc)) begin
                    set[n] = 1'b1;
                end else begin
                    bus_q[n].push_back('{addr: m_addr[n], wdata: m_wdata[n], wr: wr[n], push: cyc});
                    has_acc[n]  = 1'b1;
                    acc_cyc[n]  = cyc;
                    free_cyc[n] = c_inf;
                end
            end
        end
        exp_err_nxt = set | (exp_err & ~{2{clr}});
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++)
            step(2'b00, 2'b00, 8'($urandom), 8'($urandom), 16'($urandom), 16'($urandom), 1'b0);
    endtask

    function automatic int outstanding();
        int k;
        k = bus_q[0].size() + bus_q[1].size() + rd_q[0].size() + rd_q[1].size();
        return k + int'(busy_m(0, cyc + 1)) + int'(busy_m(1, cyc + 1));
    endfunction

    task automatic monitor_cycle();
        int   k;
        bit   e0, e1, exp_issue, exp_v;
        int   p;
        req_t rq;
        rsp_t rs;
        k  = cyc;
        e0 = (bus_q[0].size() > 0) && (bus_q[0][0].push <= k - 2);
        e1 = (bus_q[1].size() > 0) && (bus_q[1][0].push <= k - 2);
        exp_issue = (e0 || e1) && (k >= bus_next);
        check("issue", 32'(reg_wr | reg_rd), 32'(exp_issue));
        if (exp_issue && (reg_wr || reg_rd)) begin
            p  = (e0 && e1) ? int'(!last_g) : (e1 ? 1 : 0);
            rq = bus_q[p].pop_front();
            check("op", 32'({reg_wr, reg_rd}), rq.wr ? 32'h2 : 32'h1);
            check("addr", 32'(reg_addr), 32'(rq.addr));
            check("wdata", 32'(reg_wdata), 32'(rq.wdata));
            last_addr  = rq.addr;
            last_wdata = rq.wdata;
            last_g     = p[0];
            if (rq.wr) begin
                mem[rq.addr] = rq.wdata;
                free_cyc[p]  = k + 1;
                bus_next     = k + 2;
            end else begin
                rd_q[p].push_back('{data: mem[rq.addr], due: k + 1 + c_lat});
                samp_q.push_back('{data: mem[rq.addr], due: k + c_lat});
                free_cyc[p] = k + 1 + c_lat;
                bus_next    = k + 2 + c_lat;
            end
        end else begin
            check("addr_hold", 32'({reg_addr, reg_wdata}), 32'({last_addr, last_wdata}));
        end
        for (int n = 0; n < 2; n++) begin
            exp_v = (rd_q[n].size() > 0) && (rd_q[n][0].due == k);
            check("rd_valid", 32'(m_rdv[n]), 32'(exp_v));
            if (exp_v) begin
                rs = rd_q[n].pop_front();
                exp_rdata[n] = rs.data;
            end
            check("rdata", 32'(m_rdata[n]), 32'(exp_rdata[n]));
            check("busy", 32'(m_busy[n]), 32'(busy_m(n, k)));
        end
        check("err", 32'(err), 32'(exp_err));
        // Only the scheduled sample cycle carries real data; elsewhere it is noise.
        if ((samp_q.size() > 0) && (samp_q[0].due == k)) begin
            rs = samp_q.pop_front();
            reg_rdata = rs.data;
        end else begin
            reg_rdata = 16'($urandom);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) monitor_cycle();
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, w1;
        logic [1:0] wr, rd;
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        mem[8'h05] = 16'h1234;
        model_reset();
        m_addr[0] = 8'h0; m_addr[1] = 8'h0; m_wdata[0] = 16'h0; m_wdata[1] = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        idle(2);

        step(2'b01, 2'b00, 8'h12, 8'h00, 16'hBEEF, 16'h0, 1'b0);
        idle(4);
        step(2'b00, 2'b10, 8'h00, 8'h05, 16'h0, 16'h0, 1'b0);
        idle(7);
        for (int r = 0; r < 3; r++) begin
            step(2'b11, 2'b00, 8'(8'h40 + r), 8'(8'h50 + r), 16'($urandom), 16'($urandom), 1'b0);
            idle(6);
        end
        step(2'b01, 2'b00, 8'h30, 8'h00, 16'h1111, 16'h0, 1'b0);
        step(2'b01, 2'b00, 8'h31, 8'h00, 16'h2222, 16'h0, 1'b0);
        idle(5);
        step(2'b00, 2'b00, 8'h00, 8'h00, 16'h0, 16'h0, 1'b1);
        idle(3);
        step(2'b01, 2'b01, 8'h20, 8'h00, 16'hCAFE, 16'h0, 1'b0);
        idle(5);
        step(2'b00, 2'b00, 8'h00, 8'h00, 16'h0, 16'h0, 1'b1);
        idle(2);

        for (int i = 0; i < 2000; i++) begin
            wr = 2'b00; rd = 2'b00;
            for (int n = 0; n < 2; n++) begin
                w0 = $urandom_range(0, 99);
                if (w0 < 3) begin wr[n] = 1'b1; rd[n] = 1'b1; end
                else if (w0 < 18) wr[n] = 1'b1;
                else if (w0 < 35) rd[n] = 1'b1;
            end
            w1 = $urandom_range(0, 99);
            step(wr, rd, 8'($urandom), 8'($urandom), 16'($urandom), 16'($urandom), w1 < 4);
        end

        for (int i = 0; i < 100 && outstanding() != 0; i++) idle(1);
        check("drain_empty", 32'(outstanding()), 0);
        idle(2);

        // Abort a read while it waits for register data.
        step(2'b00, 2'b01, 8'h33, 8'h00, 16'h0, 16'h0, 1'b0);
        for (int i = 0; i < 20 && bus_q[0].size() != 0; i++) idle(1);
        check("rst_issue_seen", 32'(bus_q[0].size()), 0);
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(8);
        step(2'b11, 2'b00, 8'h61, 8'h62, 16'hA5A5, 16'h5A5A, 1'b0);
        idle(8);
        check("final_empty", 32'(outstanding()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
